// File: rtl/uart_cmd_parser.sv
// UART command header decoder: turns SYNC0/SYNC1/CMD/LEN_H/LEN_L/CHK frames
// into a cmd/rx_cnt request for the FIFO controller and drives its frame-end handshake.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC0   = 8'h55,
  parameter logic [7:0]  SYNC1   = 8'hAA,
  parameter int unsigned TIMEOUT = 5_000_000,
  parameter int unsigned FE_LEN  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        fifo_busy,
  input  logic        fifo_done,
  output logic [7:0]  cmd,
  output logic [15:0] rx_cnt,
  output logic        en_fc,
  output logic        fe_done,
  output logic [7:0]  err_cnt,
  output logic        parser_busy
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned FW = (FE_LEN > 1) ? $clog2(FE_LEN) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_H1,
    S_CMD,
    S_LH,
    S_LL,
    S_CHK,
    S_ISSUE,
    S_WAIT,
    S_FE,
    S_DRAIN
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [7:0]      cmd_r;
  logic [15:0]     rx_cnt_r;
  logic [TW-1:0]   tmo_cnt;
  logic [FW-1:0]   fe_cnt;

  logic            in_hdr;
  logic            timeout_hit;
  logic            cmd_legal;
  logic            frame_ok;
  logic            accept;
  logic            err_inc;
  logic            en_fc_d;
  logic            fe_done_d;

  assign in_hdr      = state inside {S_H1, S_CMD, S_LH, S_LL, S_CHK};
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout_hit = in_hdr && !rx_valid && (tmo_cnt == TW'(TIMEOUT - 1));
  assign cmd_legal   = cmd_r inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
  assign frame_ok    = cmd_legal &&
                       (rx_data == (cmd_r ^ rx_cnt_r[15:8] ^ rx_cnt_r[7:0]));
  assign parser_busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC0) next_state = S_H1;
      end
      S_H1: begin
        if (rx_valid) begin
          if (rx_data == SYNC1)      next_state = S_CMD;
          else if (rx_data == SYNC0) next_state = S_H1;
          else                       next_state = S_IDLE;
        end
      end
      S_CMD: begin
        if (rx_valid) next_state = S_LH;
      end
      S_LH: begin
        if (rx_valid) next_state = S_LL;
      end
      S_LL: begin
        if (rx_valid) next_state = S_CHK;
      end
      S_CHK: begin
        if (rx_valid) next_state = frame_ok ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        if (fifo_busy) next_state = S_WAIT;
      end
      S_WAIT: begin
        if (fifo_done) next_state = S_FE;
      end
      S_FE: begin
        if (fe_cnt == '0) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (!fifo_busy) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (timeout_hit) next_state = S_IDLE;
  end

  always_comb begin
    accept    = (state == S_CHK) && rx_valid && frame_ok;
    err_inc   = timeout_hit ||
                ((state == S_H1) && rx_valid && (rx_data != SYNC1) && (rx_data != SYNC0)) ||
                ((state == S_CHK) && rx_valid && !frame_ok);
    en_fc_d   = (state == S_ISSUE) && !fifo_busy;
    fe_done_d = 1'b0;
    if (state == S_WAIT && fifo_done) begin
      fe_done_d = 1'b1;
    end else if (state == S_FE) begin
      fe_done_d = (fe_cnt != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r    <= '0;
      rx_cnt_r <= '0;
      cmd      <= '0;
      rx_cnt   <= '0;
      en_fc    <= 1'b0;
      fe_done  <= 1'b0;
      fe_cnt   <= '0;
      tmo_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      if (rx_valid) begin
        if (state == S_CMD) cmd_r          <= rx_data;
        if (state == S_LH)  rx_cnt_r[15:8] <= rx_data;
        if (state == S_LL)  rx_cnt_r[7:0]  <= rx_data;
      end
      if (accept) begin
        cmd    <= cmd_r;
        rx_cnt <= rx_cnt_r;
      end
      en_fc   <= en_fc_d;
      fe_done <= fe_done_d;
      if (state == S_WAIT && fifo_done) begin
        fe_cnt <= FW'(FE_LEN - 1);
      end else if (state == S_FE && fe_cnt != '0) begin
        fe_cnt <= fe_cnt - FW'(1);
      end
      if (!in_hdr || rx_valid || timeout_hit) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (err_inc && err_cnt != '1) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser (TIMEOUT shortened to 100 cycles).
module tb_uart_cmd_parser;

  localparam int unsigned FE_LEN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        fifo_busy;
  logic        fifo_done;
  logic [7:0]  cmd;
  logic [15:0] rx_cnt;
  logic        en_fc;
  logic        fe_done;
  logic [7:0]  err_cnt;
  logic        parser_busy;

  int checks   = 0;
  int failures = 0;

  uart_cmd_parser #(
    .SYNC0  (8'h55),
    .SYNC1  (8'hAA),
    .TIMEOUT(100),
    .FE_LEN (FE_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .fifo_busy  (fifo_busy),
    .fifo_done  (fifo_done),
    .cmd        (cmd),
    .rx_cnt     (rx_cnt),
    .en_fc      (en_fc),
    .fe_done    (fe_done),
    .err_cnt    (err_cnt),
    .parser_busy(parser_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] lh,
                            input logic [7:0] ll, input logic [7:0] chk);
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(c);
    send_byte(lh);
    send_byte(ll);
    send_byte(chk);
  endtask

  // Walks an issued command through busy, done, frame-end and drain back to idle.
  task automatic finish_handshake();
    fifo_busy = 1'b1;
    tick();
    tick();
    fifo_done = 1'b1;
    tick();
    fifo_done = 1'b0;
    repeat (FE_LEN + 2) tick();
    fifo_busy = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (cmd !== 8'h00) begin failures++; $display("FAIL reset_cmd: got %h want 00", cmd); end
    checks++; if (rx_cnt !== 16'h0000) begin failures++; $display("FAIL reset_rx_cnt: got %h want 0000", rx_cnt); end
    checks++; if (en_fc !== 1'b0) begin failures++; $display("FAIL reset_en_fc: got %b want 0", en_fc); end
    checks++; if (fe_done !== 1'b0) begin failures++; $display("FAIL reset_fe_done: got %b want 0", fe_done); end
    checks++; if (err_cnt !== 8'h00) begin failures++; $display("FAIL reset_err_cnt: got %h want 00", err_cnt); end
    checks++; if (parser_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", parser_busy); end
    rst_n = 1'b1;
    tick();
    checks++; if (parser_busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy: got %b want 0", parser_busy); end
  endtask

  task automatic test_accept();
    int hi;
    send_frame(8'h01, 8'h00, 8'h03, 8'h02);
    checks++; if (en_fc !== 1'b0) begin failures++; $display("FAIL accept_en_fc_entry: got %b want 0", en_fc); end
    checks++; if (parser_busy !== 1'b1) begin failures++; $display("FAIL accept_busy: got %b want 1", parser_busy); end
    tick();
    checks++; if (cmd !== 8'h01) begin failures++; $display("FAIL accept_cmd: got %h want 01", cmd); end
    checks++; if (rx_cnt !== 16'h0003) begin failures++; $display("FAIL accept_rx_cnt: got %h want 0003", rx_cnt); end
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (en_fc === 1'b1) hi++;
      if (i == 2) fifo_busy = 1'b1;
      tick();
    end
    checks++; if (hi !== 3) begin failures++; $display("FAIL accept_en_fc_len: got %0d want 3", hi); end
    checks++; if (en_fc !== 1'b0) begin failures++; $display("FAIL accept_en_fc_drop: got %b want 0", en_fc); end
    checks++; if (err_cnt !== 8'h00) begin failures++; $display("FAIL accept_err_cnt: got %h want 00", err_cnt); end
    checks++; if (cmd !== 8'h01) begin failures++; $display("FAIL accept_cmd_hold: got %h want 01", cmd); end
  endtask

  task automatic test_frame_end();
    logic [7:0] fe_bits;
    fe_bits   = '0;
    fifo_done = 1'b1;
    tick();
    fifo_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fe_bits[i] = fe_done;
      tick();
    end
    checks++; if (fe_bits !== 8'h0F) begin failures++; $display("FAIL fe_done_shape: got %b want 00001111", fe_bits); end
    tick();
    checks++; if (parser_busy !== 1'b1) begin failures++; $display("FAIL drain_busy: got %b want 1", parser_busy); end
    fifo_busy = 1'b0;
    tick();
    checks++; if (parser_busy !== 1'b0) begin failures++; $display("FAIL drain_idle: got %b want 0", parser_busy); end
    checks++; if (fe_done !== 1'b0) begin failures++; $display("FAIL drain_fe_done: got %b want 0", fe_done); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h02, 8'h00, 8'h10, 8'h12);
    checks++; if (parser_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b want 1", parser_busy); end
    tick();
    checks++; if (en_fc !== 1'b1) begin failures++; $display("FAIL b2b_en_fc: got %b want 1", en_fc); end
    checks++; if (cmd !== 8'h02) begin failures++; $display("FAIL b2b_cmd: got %h want 02", cmd); end
    checks++; if (rx_cnt !== 16'h0010) begin failures++; $display("FAIL b2b_rx_cnt: got %h want 0010", rx_cnt); end
    finish_handshake();
  endtask

  task automatic test_reject();
    send_frame(8'h05, 8'h00, 8'h01, 8'h04);
    checks++; if (err_cnt !== 8'h01) begin failures++; $display("FAIL reject_illegal_err: got %h want 01", err_cnt); end
    checks++; if (parser_busy !== 1'b0) begin failures++; $display("FAIL reject_illegal_busy: got %b want 0", parser_busy); end
    tick();
    checks++; if (en_fc !== 1'b0) begin failures++; $display("FAIL reject_illegal_en_fc: got %b want 0", en_fc); end
    send_frame(8'h02, 8'h00, 8'h10, 8'h13);
    checks++; if (err_cnt !== 8'h02) begin failures++; $display("FAIL reject_chk_err: got %h want 02", err_cnt); end
    checks++; if (cmd !== 8'h02) begin failures++; $display("FAIL reject_cmd_hold: got %h want 02", cmd); end
    checks++; if (rx_cnt !== 16'h0010) begin failures++; $display("FAIL reject_rx_cnt_hold: got %h want 0010", rx_cnt); end
    send_byte(8'h00);
    send_byte(8'h55);
    send_byte(8'h00);
    checks++; if (err_cnt !== 8'h03) begin failures++; $display("FAIL reject_sync1_err: got %h want 03", err_cnt); end
    checks++; if (parser_busy !== 1'b0) begin failures++; $display("FAIL reject_sync1_busy: got %b want 0", parser_busy); end
  endtask

  task automatic test_resync();
    send_byte(8'h55);
    send_frame(8'h03, 8'h00, 8'h00, 8'h03);
    tick();
    checks++; if (en_fc !== 1'b1) begin failures++; $display("FAIL resync_en_fc: got %b want 1", en_fc); end
    checks++; if (cmd !== 8'h03) begin failures++; $display("FAIL resync_cmd: got %h want 03", cmd); end
    checks++; if (rx_cnt !== 16'h0000) begin failures++; $display("FAIL resync_rx_cnt: got %h want 0000", rx_cnt); end
    checks++; if (err_cnt !== 8'h03) begin failures++; $display("FAIL resync_err: got %h want 03", err_cnt); end
    finish_handshake();
  endtask

  task automatic test_timeout();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h04);
    repeat (99) tick();
    checks++; if (parser_busy !== 1'b1) begin failures++; $display("FAIL timeout_early: got %b want 1", parser_busy); end
    tick();
    checks++; if (parser_busy !== 1'b0) begin failures++; $display("FAIL timeout_idle: got %b want 0", parser_busy); end
    checks++; if (err_cnt !== 8'h01) begin failures++; $display("FAIL timeout_err: got %h want 01", err_cnt); end
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h06);
    repeat (99) tick();
    send_byte(8'h01);
    checks++; if (parser_busy !== 1'b1) begin failures++; $display("FAIL timeout_byte_wins_busy: got %b want 1", parser_busy); end
    checks++; if (err_cnt !== 8'h01) begin failures++; $display("FAIL timeout_byte_wins_err: got %h want 01", err_cnt); end
    send_byte(8'h02);
    send_byte(8'h05);
    tick();
    checks++; if (en_fc !== 1'b1) begin failures++; $display("FAIL timeout_frame_en_fc: got %b want 1", en_fc); end
    checks++; if (cmd !== 8'h06) begin failures++; $display("FAIL timeout_frame_cmd: got %h want 06", cmd); end
    checks++; if (rx_cnt !== 16'h0102) begin failures++; $display("FAIL timeout_frame_rx_cnt: got %h want 0102", rx_cnt); end
    fifo_busy = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_wait_ignore();
    send_frame(8'h01, 8'h00, 8'h01, 8'h00);
    checks++; if (cmd !== 8'h06) begin failures++; $display("FAIL wait_cmd: got %h want 06", cmd); end
    checks++; if (rx_cnt !== 16'h0102) begin failures++; $display("FAIL wait_rx_cnt: got %h want 0102", rx_cnt); end
    checks++; if (en_fc !== 1'b0) begin failures++; $display("FAIL wait_en_fc: got %b want 0", en_fc); end
    checks++; if (err_cnt !== 8'h01) begin failures++; $display("FAIL wait_err: got %h want 01", err_cnt); end
    checks++; if (parser_busy !== 1'b1) begin failures++; $display("FAIL wait_busy: got %b want 1", parser_busy); end
    rx_data   = 8'h55;
    rx_valid  = 1'b1;
    fifo_done = 1'b1;
    tick();
    rx_valid  = 1'b0;
    fifo_done = 1'b0;
    checks++; if (fe_done !== 1'b1) begin failures++; $display("FAIL wait_done_fe: got %b want 1", fe_done); end
  endtask

  task automatic test_reset_mid_fe();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (fe_done !== 1'b0) begin failures++; $display("FAIL rst_fe_done: got %b want 0", fe_done); end
    checks++; if (en_fc !== 1'b0) begin failures++; $display("FAIL rst_en_fc: got %b want 0", en_fc); end
    checks++; if (err_cnt !== 8'h00) begin failures++; $display("FAIL rst_err_cnt: got %h want 00", err_cnt); end
    checks++; if (parser_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", parser_busy); end
    checks++; if (cmd !== 8'h00) begin failures++; $display("FAIL rst_cmd: got %h want 00", cmd); end
    tick();
    rst_n     = 1'b1;
    fifo_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (fe_done !== 1'b0 || en_fc !== 1'b0) begin
        failures++; $display("FAIL rst_glitch: got fe_done=%b en_fc=%b want 0 0", fe_done, en_fc);
      end
    end
    fifo_done = 1'b0;
    fifo_busy = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 300; i++) begin
      send_byte(8'h55);
      send_byte(8'h00);
      if (i == 254) begin
        checks++; if (err_cnt !== 8'hFE) begin failures++; $display("FAIL sat_254: got %h want fe", err_cnt); end
      end
      if (i == 255) begin
        checks++; if (err_cnt !== 8'hFF) begin failures++; $display("FAIL sat_255: got %h want ff", err_cnt); end
      end
    end
    checks++; if (err_cnt !== 8'hFF) begin failures++; $display("FAIL sat_300: got %h want ff", err_cnt); end
    checks++; if (parser_busy !== 1'b0) begin failures++; $display("FAIL sat_busy: got %b want 0", parser_busy); end
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    fifo_busy = 1'b0;
    fifo_done = 1'b0;
    test_reset();
    test_accept();
    test_frame_end();
    test_back_to_back();
    test_reject();
    test_resync();
    test_timeout();
    test_wait_ignore();
    test_reset_mid_fe();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
